sub_shift_stage: RTL and testbench
==================================

Name: sub_shift_stage

Overview:
- Iterative SubNibbles + ShiftRows round stage for the 4x4 nibble-state lightweight cipher datapath.
- Sits directly upstream of the MixColumn stage and produces the state that stage consumes.
- Processes one row per cycle through four 4-bit S-boxes.
- Start/busy/done handshake; 4-cycle latency.

Parameters:
- INV, 0: 0 = forward S-box with left row rotation (encrypt); 1 = inverse S-box with right row rotation (decrypt).

Ports:
- clock  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-low reset
- start  input  1  request; st_in is sampled when start=1 and the FSM is IDLE
- st_in  input  4 x [0:3][0:3]  input state, unpacked nibble array indexed [row][col]
- state_out  output  4 x [0:3][0:3]  result state, registered
- busy  output  1  high while a transformation is in progress
- done  output  1  one-cycle pulse; state_out is complete and stable while done=1

Behaviour:
- Clock and reset (already decided): one clock, `clock`; reset `rst` is synchronous and active-low.
- Reset: sampled on a clock edge with rst=0.
  - FSM goes to IDLE; row counter = 0.
  - busy=0, done=0, every state_out nibble = 0, internal latch = 0.
  - A reset mid-operation aborts the operation; no done is produced.
- FSM states: IDLE, RUN.
- IDLE:
  - done<=0.
  - If start=1: latch st_in into the internal buffer, row<=0, busy<=1, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - Compute row `row` from the buffer and write all four nibbles of state_out[row].
  - Then row<=row+1.
  - When row==3: done<=1, busy<=0, go to IDLE.
- Latency: start sampled at edge k; rows 0..3 are written at edges k+1..k+4; done is high in the cycle after edge k+4.
- Throughput: start may be asserted while done=1 (the FSM is already IDLE). It is accepted at that edge, giving back-to-back operations every 4 cycles.
- start while busy=1 is ignored; it is neither queued nor latched.
- st_in may change freely after it is sampled; only the latched copy is used.
- Row function, forward (INV=0): state_out[r][c] = S(buf[r][(c+r) mod 4]).
- Row function, inverse (INV=1): state_out[r][c] = Sinv(buf[r][(c-r) mod 4]).
- Column indices are 2-bit and wrap modulo 4.
- S-box (hex, input 0..F): C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
- Sinv is its exact inverse: 5 E F 8 C 1 2 D B 4 6 3 0 7 9 A.
- state_out rows update progressively during RUN. Rows not yet written hold the previous result. Consumers sample only when done=1.
- state_out holds its value indefinitely after done, until the next operation or reset.
- The row counter is 2 bits wide. RUN never wraps it; the transition to IDLE occurs at row==3.

Decomposition:
- Shared package `cipher_pkg`:
  - 4-bit nibble typedef and state array typedef.
  - S-box and inverse S-box constant arrays.
  - FSM state enum (IDLE, RUN).
  - NROW/NCOL = 4 constants.
- Sub-module `sbox4`: combinational 4-bit lookup with INV parameter.
- Four `sbox4` instances, one per column of the current row. Row select and rotation mux sit in front of them.

Test Plan:
- Reset: hold rst=0 for 2 edges, with start=1 during reset → busy=0, done=0, all state_out=0; no operation starts.
- Forward vector, INV=0, st_in[r][c]=4r+c → done at edge k+4 with rows: C56B / 0AD9 / F83E / 2471 (hex, col0..3); busy high for exactly 4 cycles.
- All-zero st_in, INV=0 → all state_out = C. Then start again in the done cycle with the previous output vector and INV=1 → output 0s; done 4 cycles later.
- Inverse round-trip, INV=1, input C56B/0AD9/F83E/2471 → output 0123/4567/89AB/CDEF.
- start pulsed at cycle 2 of RUN with a different st_in → ignored; result equals the first operation's; exactly one done pulse.
- Reset asserted at the 3rd RUN edge → next cycle busy=0, done=0, state_out all 0; no done follows. A new start after reset completes normally.

Source files
------------

// File: rtl/cipher_pkg.sv
// ---------------------------------------------------------------------------
// cipher_pkg
// Types and constants for the 4x4 nibble-state lightweight cipher datapath.
//   nibble_t : one 4-bit cell of the cipher state
//   state_t  : full state, unpacked [row][col]
//   fsm_e    : control states for the iterative round stages
//   SBOX / SBOX_INV : forward S-box and its exact inverse
// ---------------------------------------------------------------------------
package cipher_pkg;

   localparam int NROW = 4;
   localparam int NCOL = 4;

   typedef logic [3:0] nibble_t;
   typedef nibble_t state_t [0:NROW-1][0:NCOL-1];

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fsm_e;

   localparam nibble_t SBOX [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   localparam nibble_t SBOX_INV [16] = '{
      4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
      4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
   };

endpackage

// File: rtl/sbox4.sv
// ---------------------------------------------------------------------------
// sbox4
// Purely combinational 4-bit S-box lookup.
//   INV   : 0 = forward S-box, 1 = inverse S-box
//   nib_i : input nibble
//   nib_o : substituted nibble
// ---------------------------------------------------------------------------
module sbox4
   import cipher_pkg::*;
#(
   parameter bit INV = 1'b0
) (
   input  logic [3:0] nib_i,
   output logic [3:0] nib_o
);

   // The direction is fixed at elaboration, so only one table survives synthesis.
   assign nib_o = INV ? SBOX_INV[nib_i] : SBOX[nib_i];

endmodule

// File: rtl/sub_shift_stage.sv
// ---------------------------------------------------------------------------
// sub_shift_stage
// Iterative SubNibbles + ShiftRows round stage. One row of the latched state
// is rotated and pushed through four S-boxes per cycle, so a full state takes
// four cycles after start is accepted.
//   INV       : 0 = forward S-box + left row rotation, 1 = inverse + right rotation
//   clock     : system clock, rising edge
//   rst       : synchronous active-low reset
//   start     : request, accepted only while idle
//   st_in     : input state [row][col], sampled when start is accepted
//   state_out : registered result state, rows written progressively
//   busy      : high while a transformation is in progress
//   done      : one-cycle pulse, state_out complete while high
// ---------------------------------------------------------------------------
module sub_shift_stage
   import cipher_pkg::*;
#(
   parameter bit INV = 1'b0
) (
   input  logic   clock,
   input  logic   rst,
   input  logic   start,
   input  state_t st_in,
   output state_t state_out,
   output logic   busy,
   output logic   done
);

   fsm_e       fsm_q;
   logic [1:0] row_q;
   logic [1:0] row_d;
   state_t     buf_q;
   state_t     out_q;
   logic       busy_q;
   logic       done_q;

   logic [1:0] colSel  [NCOL];
   nibble_t    sboxIn  [NCOL];
   nibble_t    sboxOut [NCOL];

   assign row_d = row_q + 2'd1;

   // ShiftRows is folded into the read side: column c of the current row is
   // fed from buffer column c+row (forward) or c-row (inverse). The 2-bit
   // index arithmetic wraps modulo 4 for free.
   always_comb begin
      for (int c = 0; c < NCOL; c++) begin
         colSel[c] = INV ? (2'(c) - row_q) : (2'(c) + row_q);
         sboxIn[c] = buf_q[row_q][colSel[c]];
      end
   end

   for (genvar c = 0; c < NCOL; c++) begin : gCol
      sbox4 #(.INV(INV)) uSbox (
         .nib_i(sboxIn[c]),
         .nib_o(sboxOut[c])
      );
   end

   // Control FSM and all registered outputs. A start seen while running is
   // simply not looked at, and since the FSM is already IDLE during the done
   // cycle a new start there is accepted for back-to-back operation.
   always_ff @(posedge clock) begin
      if (!rst) begin
         fsm_q  <= IDLE;
         row_q  <= 2'd0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         for (int r = 0; r < NROW; r++) begin
            for (int c = 0; c < NCOL; c++) begin
               buf_q[r][c] <= '0;
               out_q[r][c] <= '0;
            end
         end
      end else begin
         case (fsm_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  buf_q  <= st_in;
                  row_q  <= 2'd0;
                  busy_q <= 1'b1;
                  fsm_q  <= RUN;
               end
            end
            RUN: begin
               for (int c = 0; c < NCOL; c++) begin
                  out_q[row_q][c] <= sboxOut[c];
               end
               row_q <= row_d;
               if (row_q == 2'd3) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  fsm_q  <= IDLE;
               end
            end
            default: begin
               fsm_q <= IDLE;
            end
         endcase
      end
   end

   assign state_out = out_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_sub_shift_stage.sv
// ---------------------------------------------------------------------------
// tb_sub_shift_stage
// Drives a forward (INV=0) and an inverse (INV=1) instance side by side and
// compares both against a behavioural model every cycle, with literal
// vectors at each completion.
// ---------------------------------------------------------------------------
module tb_sub_shift_stage
   import cipher_pkg::*;
;

   logic   clock;
   logic   rst;
   logic   startF, startI;
   state_t inF, inI, outF, outI;
   logic   busyF, busyI, doneF, doneI;

   int     checkCount = 0;
   int     passCount  = 0;
   int     doneCountF = 0;
   bit     checkEn    = 1'b0;

   localparam logic [3:0] TB_S    [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
   localparam logic [3:0] TB_SINV [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                           4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

   // Model state per instance (0 = forward, 1 = inverse).
   logic [3:0] mOut [2][4][4];
   logic [3:0] mRes [2][4][4];
   int         mStep [2];
   logic       mBusy [2];
   logic       mDone [2];

   sub_shift_stage #(.INV(1'b0)) dutF (
      .clock(clock), .rst(rst), .start(startF), .st_in(inF),
      .state_out(outF), .busy(busyF), .done(doneF)
   );

   sub_shift_stage #(.INV(1'b1)) dutI (
      .clock(clock), .rst(rst), .start(startI), .st_in(inI),
      .state_out(outI), .busy(busyI), .done(doneI)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [63:0] packS(input state_t s);
      logic [63:0] p;
      p = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            p = {p[59:0], s[r][c]};
      return p;
   endfunction

   function automatic logic [63:0] packM(input int i);
      logic [63:0] p;
      p = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            p = {p[59:0], mOut[i][r][c]};
      return p;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act !== exp)
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      else
         passCount++;
   endtask

   // Behavioural model: an accepted start fixes the whole result at once from
   // the round rule; the rows then appear one per edge, done follows the last.
   always @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            mStep[i] = -1;
            mBusy[i] = 1'b0;
            mDone[i] = 1'b0;
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++)
                  mOut[i][r][c] = 4'h0;
         end else if (mStep[i] >= 0) begin
            for (int c = 0; c < 4; c++)
               mOut[i][mStep[i]][c] = mRes[i][mStep[i]][c];
            mStep[i] = mStep[i] + 1;
            if (mStep[i] == 4) begin
               mStep[i] = -1;
               mBusy[i] = 1'b0;
               mDone[i] = 1'b1;
            end
         end else begin
            mDone[i] = 1'b0;
            if ((i == 0) ? startF : startI) begin
               for (int r = 0; r < 4; r++)
                  for (int c = 0; c < 4; c++)
                     if (i == 0)
                        mRes[i][r][c] = TB_S[inF[r][(c + r) % 4]];
                     else
                        mRes[i][r][c] = TB_SINV[inI[r][(c - r + 4) % 4]];
               mStep[i] = 0;
               mBusy[i] = 1'b1;
            end
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clock) begin
      if (checkEn) begin
         checkOutput("busyF", 64'(busyF), 64'(mBusy[0]));
         checkOutput("doneF", 64'(doneF), 64'(mDone[0]));
         checkOutput("outF",  packS(outF), packM(0));
         checkOutput("busyI", 64'(busyI), 64'(mBusy[1]));
         checkOutput("doneI", 64'(doneI), 64'(mDone[1]));
         checkOutput("outI",  packS(outI), packM(1));
      end
   end

   always @(negedge clock) begin
      if (doneF === 1'b1) doneCountF++;
   end

   // Start one instance for exactly one edge; returns at the negedge after it.
   task automatic applyStimulus(input bit sel, input state_t v);
      if (sel) begin inI = v; startI = 1'b1; end
      else     begin inF = v; startF = 1'b1; end
      @(negedge clock);
      startF = 1'b0;
      startI = 1'b0;
   endtask

   // Wait for done on one instance, counting busy cycles and elapsed negedges.
   task automatic waitDone(input bit sel, output int busyCycles, output int cycles);
      busyCycles = 0;
      cycles     = 0;
      while (((sel ? doneI : doneF) !== 1'b1) && cycles < 20) begin
         if ((sel ? busyI : busyF) === 1'b1) busyCycles++;
         @(negedge clock);
         cycles++;
      end
      if ((sel ? doneI : doneF) !== 1'b1)
         checkOutput(sel ? "timeoutI" : "timeoutF", 64'd0, 64'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      state_t vecA, vecZ, vecF;
      int     bc, cy, dc;

      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            vecA[r][c] = 4'(4 * r + c);
            vecZ[r][c] = 4'h0;
            vecF[r][c] = 4'hF;
         end

      // Reset with start held high: nothing must start.
      checkEn = 1'b1;
      rst = 1'b0; startF = 1'b1; startI = 1'b1; inF = vecA; inI = vecA;
      @(negedge clock);
      @(negedge clock);
      checkOutput("rstBusyF", 64'(busyF), 64'd0);
      checkOutput("rstDoneF", 64'(doneF), 64'd0);
      checkOutput("rstOutF",  packS(outF), 64'h0);
      checkOutput("rstOutI",  packS(outI), 64'h0);
      rst = 1'b1; startF = 1'b0; startI = 1'b0;
      @(negedge clock);
      checkOutput("idleBusyF", 64'(busyF), 64'd0);

      // Forward vector 0..F.
      applyStimulus(1'b0, vecA);
      waitDone(1'b0, bc, cy);
      checkOutput("fwdBusyCycles", 64'(bc), 64'd4);
      checkOutput("fwdLatency",    64'(cy), 64'd4);
      checkOutput("fwdVector", packS(outF), 64'hC56B_0AD9_F83E_2471);

      // Done cycle: round-trip on the inverse instance, back-to-back zeros on forward.
      inI = outF; startI = 1'b1;
      inF = vecZ; startF = 1'b1;
      @(negedge clock);
      startF = 1'b0; startI = 1'b0;
      inF = vecF; inI = vecF;
      waitDone(1'b1, bc, cy);
      checkOutput("invLatency", 64'(cy), 64'd4);
      checkOutput("invRoundTrip", packS(outI), 64'h0123_4567_89AB_CDEF);
      checkOutput("fwdZeroDone", 64'(doneF), 64'd1);
      checkOutput("fwdZero", packS(outF), 64'hCCCC_CCCC_CCCC_CCCC);

      // Done cycle again: all-C state through the inverse gives zeros.
      inI = outF; startI = 1'b1;
      @(negedge clock);
      startI = 1'b0;
      waitDone(1'b1, bc, cy);
      checkOutput("invZeroLatency", 64'(cy), 64'd4);
      checkOutput("invZero", packS(outI), 64'h0);
      @(negedge clock);
      checkOutput("invHold", packS(outI), 64'h0);

      // Start during RUN is ignored.
      @(negedge clock);
      dc = doneCountF;
      applyStimulus(1'b0, vecA);
      @(negedge clock);
      inF = vecF; startF = 1'b1;
      @(negedge clock);
      startF = 1'b0;
      waitDone(1'b0, bc, cy);
      checkOutput("ignoreStart", packS(outF), 64'hC56B_0AD9_F83E_2471);
      repeat (6) @(negedge clock);
      checkOutput("singleDone", 64'(doneCountF - dc), 64'd1);
      checkOutput("holdAfterDone", packS(outF), 64'hC56B_0AD9_F83E_2471);

      // Reset at the third RUN edge aborts the operation.
      dc = doneCountF;
      applyStimulus(1'b0, vecZ);
      @(negedge clock);
      @(negedge clock);
      rst = 1'b0;
      @(negedge clock);
      rst = 1'b1;
      checkOutput("abortBusy", 64'(busyF), 64'd0);
      checkOutput("abortDone", 64'(doneF), 64'd0);
      checkOutput("abortOut",  packS(outF), 64'h0);
      repeat (6) @(negedge clock);
      checkOutput("abortNoDone", 64'(doneCountF - dc), 64'd0);

      // A fresh operation after the abort completes normally.
      applyStimulus(1'b0, vecA);
      waitDone(1'b0, bc, cy);
      checkOutput("postAbortLatency", 64'(cy), 64'd4);
      checkOutput("postAbort", packS(outF), 64'hC56B_0AD9_F83E_2471);
      @(negedge clock);

      checkEn = 1'b0;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
